// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single GPR write port between in-order writeback and a queued long-latency result source.
// Optional macro RF_WPORT_STARVE_GUARD_EN lets a starved FIFO head take the port by stalling writeback one cycle.
module rf_wport_arbiter #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic        wb_ready_go,
  input  logic        lu_valid,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] lu_pending
);

  localparam int PW = $clog2(LU_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LU_DEPTH);

  logic [4:0]    r_dest [LU_DEPTH];
  logic [31:0]   r_data [LU_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_wb_req;
  logic          w_lu_req;
  logic          w_force;
  logic          w_wb_grant;
  logic          w_lu_grant;
  logic          w_push;
  logic [PW-1:0] w_off;
  logic [31:0]   w_pending;

  // Requests are masked during reset so nothing reaches the register file.
  assign w_wb_req = ~reset & wb_valid & wb_we & (wb_dest != 5'd0);
  assign w_lu_req = ~reset & (r_count != {CW{1'b0}});
  assign lu_ready = ~reset & (r_count < DEPTH_C);
  assign w_push   = lu_valid & lu_ready & (lu_dest != 5'd0);

`ifdef RF_WPORT_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;

  assign w_force = w_wb_req & w_lu_req & (r_starve >= LIMIT_C);

  // Count cycles the FIFO head loses to writeback; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= {SW{1'b0}};
    end else if (!w_lu_req || w_lu_grant) begin
      r_starve <= {SW{1'b0}};
    end else if (w_wb_grant && (r_starve < LIMIT_C)) begin
      r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= r_starve;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_wb_grant  = w_wb_req & ~w_force;
  assign w_lu_grant  = w_lu_req & ~w_wb_grant;
  assign wb_ready_go = ~w_force;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_lu_grant) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_lu_grant})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; occupancy alone defines validity so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wr_ptr] <= lu_dest;
      r_data[r_wr_ptr] <= lu_data;
    end
  end

  // Pending scoreboard: slot i is live when its distance from the read pointer is below count.
  always_comb begin
    w_pending = 32'd0;
    w_off     = {PW{1'b0}};
    for (int i = 0; i < LU_DEPTH; i++) begin
      w_off     = PW'(i) - r_rd_ptr;
      w_pending = w_pending | ((CW'(w_off) < r_count) ? (32'd1 << r_dest[i]) : 32'd0);
    end
    w_pending[0] = 1'b0;
  end

  assign lu_pending = w_pending;

  // Write-port mux driven by the grant.
  always_comb begin
    if (w_wb_grant) begin
      rf_we    = 1'b1;
      rf_waddr = wb_dest;
      rf_wdata = wb_data;
    end else if (w_lu_grant) begin
      rf_we    = 1'b1;
      rf_waddr = r_dest[r_rd_ptr];
      rf_wdata = r_data[r_rd_ptr];
    end else begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter; inputs change on the falling edge, outputs sampled 1ns later.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_ready_go;
  logic        lu_valid;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] lu_pending;

  int n_cmp = 0;
  int n_err = 0;

  rf_wport_arbiter #(.LU_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_ready_go(wb_ready_go),
    .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .lu_pending(lu_pending)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_we = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_dest = 5'd0; lu_data = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd3; wb_data = 32'h55;
    lu_valid = 1'b1; lu_dest = 5'd2; lu_data = 32'h1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending, wb_ready_go} !== {1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b we=%b a=%0d d=%h p=%h go=%b want rdy=0 we=0 a=0 d=0 p=0 go=1",
               lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending, wb_ready_go);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({rf_we, lu_ready, lu_pending, wb_ready_go} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
        n_err++;
        $display("FAIL idle_%0d: got we=%b rdy=%b p=%h go=%b want we=0 rdy=1 p=0 go=1",
                 i, rf_we, lu_ready, lu_pending, wb_ready_go);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd5; wb_data = 32'h1234;
    #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, wb_ready_go} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL wb_write: got we=%b a=%0d d=%h go=%b want we=1 a=5 d=1234 go=1", rf_we, rf_waddr, rf_wdata, wb_ready_go);
    end
    @(negedge clk);
    wb_dest = 5'd0;
    #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
      n_err++;
      $display("FAIL wb_r0: got we=%b a=%0d d=%h want we=0 a=0 d=0", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    wb_dest = 5'd5; wb_we = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL wb_no_we: got we=%b want 0", rf_we);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lu_single();
    lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'hDEAD;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, lu_pending} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL lu_offer: got rdy=%b we=%b p=%h want rdy=1 we=0 p=0", lu_ready, rf_we, lu_pending);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    #1;
    n_cmp++;
    if ({lu_pending, rf_we, rf_waddr, rf_wdata} !== {32'h80, 1'b1, 5'd7, 32'hDEAD}) begin
      n_err++;
      $display("FAIL lu_write: got p=%h we=%b a=%0d d=%h want p=80 we=1 a=7 d=dead", lu_pending, rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({lu_pending, rf_we} !== {32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL lu_after: got p=%h we=%b want p=0 we=0", lu_pending, rf_we);
    end
    lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'hBAD;
    #1;
    n_cmp++;
    if (lu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lu_r0_ready: got %b want 1", lu_ready);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    #1;
    n_cmp++;
    if ({rf_we, lu_pending} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL lu_r0_drop: got we=%b p=%h want we=0 p=0", rf_we, lu_pending);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd9; wb_data = 32'hA0;
    lu_valid = 1'b1; lu_dest = 5'd3; lu_data = 32'h111;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd9, 32'hA0}) begin
      n_err++;
      $display("FAIL b2b_push1: got rdy=%b we=%b a=%0d d=%h want rdy=1 we=1 a=9 d=a0", lu_ready, rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    wb_data = 32'hA1; lu_dest = 5'd4; lu_data = 32'h222;
    #1;
    n_cmp++;
    if ({lu_ready, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd9, 32'hA1, 32'h8}) begin
      n_err++;
      $display("FAIL b2b_push2: got rdy=%b a=%0d d=%h p=%h want rdy=1 a=9 d=a1 p=8", lu_ready, rf_waddr, rf_wdata, lu_pending);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_data = 32'hA2 + 32'(i);
      #1;
      n_cmp++;
      if ({lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b0, 1'b1, 5'd9, 32'hA2 + 32'(i), 32'h18}) begin
        n_err++;
        $display("FAIL b2b_full_%0d: got rdy=%b we=%b a=%0d d=%h p=%h want rdy=0 we=1 a=9 d=%h p=18",
                 i, lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending, 32'hA2 + 32'(i));
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'h111}) begin
      n_err++;
      $display("FAIL b2b_drain1: got rdy=%b we=%b a=%0d d=%h want rdy=0 we=1 a=3 d=111", lu_ready, rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 1'b1, 5'd4, 32'h222, 32'h10}) begin
      n_err++;
      $display("FAIL b2b_drain2: got rdy=%b we=%b a=%0d d=%h p=%h want rdy=1 we=1 a=4 d=222 p=10",
               lu_ready, rf_we, rf_waddr, rf_wdata, lu_pending);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rf_we, lu_pending} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL b2b_empty: got we=%b p=%h want we=0 p=0", rf_we, lu_pending);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starve();
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd9; wb_data = 32'hB0;
    lu_valid = 1'b1; lu_dest = 5'd12; lu_data = 32'hC0DE;
    #1;
    n_cmp++;
    if ({rf_waddr, rf_wdata} !== {5'd9, 32'hB0}) begin
      n_err++;
      $display("FAIL starve_push: got a=%0d d=%h want a=9 d=b0", rf_waddr, rf_wdata);
    end
    @(negedge clk);
    lu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if ({wb_ready_go, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd9, 32'hB0}) begin
        n_err++;
        $display("FAIL starve_lose_%0d: got go=%b we=%b a=%0d d=%h want go=1 we=1 a=9 d=b0",
                 i, wb_ready_go, rf_we, rf_waddr, rf_wdata);
      end
      @(negedge clk);
    end
`ifdef RF_WPORT_STARVE_GUARD_EN
    #1;
    n_cmp++;
    if ({wb_ready_go, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd12, 32'hC0DE}) begin
      n_err++;
      $display("FAIL starve_force: got go=%b we=%b a=%0d d=%h want go=0 we=1 a=12 d=c0de",
               wb_ready_go, rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({wb_ready_go, rf_waddr, rf_wdata, lu_pending} !== {1'b1, 5'd9, 32'hB0, 32'd0}) begin
      n_err++;
      $display("FAIL starve_wb_next: got go=%b a=%0d d=%h p=%h want go=1 a=9 d=b0 p=0",
               wb_ready_go, rf_waddr, rf_wdata, lu_pending);
    end
    @(negedge clk);
    wb_valid = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({wb_ready_go, rf_waddr, lu_pending} !== {1'b1, 5'd9, 32'h1000}) begin
        n_err++;
        $display("FAIL nostarve_%0d: got go=%b a=%0d p=%h want go=1 a=9 p=1000", i, wb_ready_go, rf_waddr, lu_pending);
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hC0DE}) begin
      n_err++;
      $display("FAIL nostarve_drain: got we=%b a=%0d d=%h want we=1 a=12 d=c0de", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
`endif
    idle_inputs();
  endtask

  task automatic test_reset_flush();
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd9; wb_data = 32'hE0;
    lu_valid = 1'b1; lu_dest = 5'd20; lu_data = 32'h20;
    @(negedge clk);
    lu_dest = 5'd21; lu_data = 32'h21;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rf_we, lu_ready, lu_pending} !== {1'b0, 1'b0, 32'h0030_0000}) begin
      n_err++;
      $display("FAIL flush_in_reset: got we=%b rdy=%b p=%h want we=0 rdy=0 p=00300000", rf_we, lu_ready, lu_pending);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({lu_ready, rf_we, lu_pending} !== {1'b1, 1'b0, 32'd0}) begin
        n_err++;
        $display("FAIL flush_after_%0d: got rdy=%b we=%b p=%h want rdy=1 we=0 p=0", i, lu_ready, rf_we, lu_pending);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_wb_only();
    test_lu_single();
    test_back_to_back();
    test_starve();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
